freq_meter: RTL

FREQ_METER -- requirements
Module: freq_meter

---
 rtl/freq_meter_pkg.sv | 37 +++
 rtl/freq_meter_sync_edge.sv | 32 +++
 rtl/freq_meter.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/freq_meter_pkg.sv
// Shared definitions for the frequency meter: FSM encoding, gate divisors,
// result scale factors and datapath widths.
package freq_meter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_GATE = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int CNT_W   = 32;  // edge counter and result width
  localparam int GATE_W  = 32;  // gate-cycle counter width
  localparam int SCALE_W = 10;  // wide enough for the largest scale (1000)
  localparam int PROD_W  = CNT_W + SCALE_W;

  // Gate divisors: G = CLK_HZ / DIV_n for mode n.
  localparam int unsigned DIV_0 = 1;
  localparam int unsigned DIV_1 = 10;
  localparam int unsigned DIV_2 = 100;
  localparam int unsigned DIV_3 = 1000;

  // Result scale: a window of 1/S seconds needs its count multiplied by S.
  localparam logic [SCALE_W-1:0] SCALE_0 = 10'd1;
  localparam logic [SCALE_W-1:0] SCALE_1 = 10'd10;
  localparam logic [SCALE_W-1:0] SCALE_2 = 10'd100;
  localparam logic [SCALE_W-1:0] SCALE_3 = 10'd1000;

  function automatic logic [SCALE_W-1:0] mode_scale(input logic [1:0] mode);
    case (mode)
      2'b00:   return SCALE_0;
      2'b01:   return SCALE_1;
      2'b10:   return SCALE_2;
      default: return SCALE_3;
    endcase
  endfunction

endpackage

// File: rtl/freq_meter_sync_edge.sv
// Brings the asynchronous measured signal into the clock domain and flags
// each low-to-high transition for one cycle.
//   clk_i  : reference clock
//   rst_i  : asynchronous active-high reset
//   sig_i  : asynchronous input signal
//   rise_o : one-cycle pulse per synchronised rising edge
module sync_edge (
  input  logic clk_i,
  input  logic rst_i,
  input  logic sig_i,
  output logic rise_o
);

  logic sync1_q;
  logic sync2_q;
  logic hist_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      hist_q  <= 1'b0;
    end else begin
      sync1_q <= sig_i;
      sync2_q <= sync1_q;
      hist_q  <= sync2_q;
    end
  end

  assign rise_o = sync2_q & ~hist_q;

endmodule

// File: rtl/freq_meter.sv
// Gated-window frequency meter. Counts synchronised rising edges of sig_in
// over a window of G reference cycles and publishes edges*S in Hz.
//   clk_50MHz : reference clock (CLK_HZ Hz)
//   rst       : asynchronous active-high reset
//   run       : continuous measurement enable
//   m1, m0    : window select (1 s, 100 ms, 10 ms, 1 ms)
//   sig_in    : measured signal, asynchronous
//   freq_hz   : last published frequency
//   valid     : one-cycle pulse when freq_hz is published
//   ovf       : last published result saturated
//   busy      : gate window open
//
// state   | meaning
// IDLE    | waiting for run
// GATE    | window open, counting edges
// DONE    | one cycle, result published (valid)
module freq_meter
  import freq_meter_pkg::*;
#(
  parameter int unsigned CLK_HZ = 50000000
) (
  input  logic              clk_50MHz,
  input  logic              rst,
  input  logic              run,
  input  logic              m1,
  input  logic              m0,
  input  logic              sig_in,
  output logic [CNT_W-1:0]  freq_hz,
  output logic              valid,
  output logic              ovf,
  output logic              busy
);

  localparam logic [GATE_W-1:0] G_LAST_0 = GATE_W'(CLK_HZ / DIV_0 - 1);
  localparam logic [GATE_W-1:0] G_LAST_1 = GATE_W'(CLK_HZ / DIV_1 - 1);
  localparam logic [GATE_W-1:0] G_LAST_2 = GATE_W'(CLK_HZ / DIV_2 - 1);
  localparam logic [GATE_W-1:0] G_LAST_3 = GATE_W'(CLK_HZ / DIV_3 - 1);

  state_t             state_q, state_d;
  logic [1:0]         mode_q;
  logic [1:0]         win_mode_q, win_mode_d;
  logic [GATE_W-1:0]  gate_cnt_q, gate_cnt_d;
  logic [CNT_W-1:0]   edge_cnt_q, edge_cnt_d;
  logic               edge_sat_q, edge_sat_d;
  logic [CNT_W-1:0]   freq_q, freq_d;
  logic               ovf_q, ovf_d;

  logic               rise;
  logic [GATE_W-1:0]  g_last;
  logic [CNT_W-1:0]   cnt_next;
  logic               sat_next;
  logic [PROD_W-1:0]  prod;
  logic               prod_ovf;

  sync_edge u_sync_edge (
    .clk_i  (clk_50MHz),
    .rst_i  (rst),
    .sig_i  (sig_in),
    .rise_o (rise)
  );

  // Window length and scale follow the mode latched at window start, so a
  // mode change is seen as a mismatch against mode_q.
  always_comb begin
    case (win_mode_q)
      2'b00:   g_last = G_LAST_0;
      2'b01:   g_last = G_LAST_1;
      2'b10:   g_last = G_LAST_2;
      default: g_last = G_LAST_3;
    endcase
  end

  always_comb begin
    cnt_next = edge_cnt_q;
    sat_next = edge_sat_q;
    if (rise) begin
      if (&edge_cnt_q) sat_next = 1'b1;
      else             cnt_next = edge_cnt_q + CNT_W'(1);
    end
  end

  // Result is formed from the count including the last gate cycle's edge,
  // so freq_hz is already updated while valid is high.
  assign prod     = PROD_W'(cnt_next) * PROD_W'(mode_scale(win_mode_q));
  assign prod_ovf = |prod[PROD_W-1:CNT_W];

  always_comb begin
    state_d    = state_q;
    win_mode_d = win_mode_q;
    gate_cnt_d = gate_cnt_q;
    edge_cnt_d = edge_cnt_q;
    edge_sat_d = edge_sat_q;
    freq_d     = freq_q;
    ovf_d      = ovf_q;
    case (state_q)
      ST_IDLE: begin
        if (run) begin
          state_d    = ST_GATE;
          win_mode_d = mode_q;
          gate_cnt_d = '0;
          edge_cnt_d = '0;
          edge_sat_d = 1'b0;
        end
      end
      ST_GATE: begin
        if (!run) begin
          state_d = ST_IDLE;
        end else if (mode_q != win_mode_q) begin
          // Abort beats a coinciding last cycle: restart with the new mode.
          win_mode_d = mode_q;
          gate_cnt_d = '0;
          edge_cnt_d = '0;
          edge_sat_d = 1'b0;
        end else begin
          edge_cnt_d = cnt_next;
          edge_sat_d = sat_next;
          if (gate_cnt_q == g_last) begin
            state_d = ST_DONE;
            freq_d  = prod_ovf ? '1 : prod[CNT_W-1:0];
            ovf_d   = sat_next | prod_ovf;
          end else begin
            gate_cnt_d = gate_cnt_q + GATE_W'(1);
          end
        end
      end
      ST_DONE: begin
        if (run) begin
          state_d    = ST_GATE;
          win_mode_d = mode_q;
          gate_cnt_d = '0;
          edge_cnt_d = '0;
          edge_sat_d = 1'b0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_50MHz or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      mode_q     <= 2'b00;
      win_mode_q <= 2'b00;
      gate_cnt_q <= '0;
      edge_cnt_q <= '0;
      edge_sat_q <= 1'b0;
      freq_q     <= '0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      mode_q     <= {m1, m0};
      win_mode_q <= win_mode_d;
      gate_cnt_q <= gate_cnt_d;
      edge_cnt_q <= edge_cnt_d;
      edge_sat_q <= edge_sat_d;
      freq_q     <= freq_d;
      ovf_q      <= ovf_d;
    end
  end

  assign freq_hz = freq_q;
  assign ovf     = ovf_q;
  assign busy    = (state_q == ST_GATE);
  assign valid   = (state_q == ST_DONE);

endmodule
